// File: rtl/debounce_toggle_ctrl.sv
// Push-button debouncer: a two-flop synchronizer feeds a four-state qualifier.
// The tick divider and stability counter only run while a level change is pending.
module debounce_toggle_ctrl #(
   parameter int TICK_DIV     = 4,
   parameter int STABLE_TICKS = 3,
   parameter int CNT_W        = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             btn_in,
   output logic             db_level,
   output logic             rise_pulse,
   output logic             fall_pulse,
   output logic             toggle_out,
   output logic [CNT_W-1:0] press_cnt,
   output logic             busy
);

   localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int STAB_W = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
   localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_TICKS - 1);

   typedef enum logic [1:0] {LOW, WAIT_HIGH, HIGH, WAIT_LOW} state_t;

   state_t              state;
   logic                sync1;
   logic                btn_s;
   logic [DIV_W-1:0]    div_cnt;
   logic [STAB_W-1:0]   stab_cnt;
   logic                tick;

   assign tick = (div_cnt == DIV_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b0;
         btn_s <= 1'b0;
      end else begin
         sync1 <= btn_in;
         btn_s <= sync1;
      end
   end

   // Counters are zero whenever a WAIT state is entered or left; aborts only drop busy.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= LOW;
         div_cnt    <= '0;
         stab_cnt   <= '0;
         db_level   <= 1'b0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
         toggle_out <= 1'b0;
         press_cnt  <= '0;
         busy       <= 1'b0;
      end else begin
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
         case (state)
            LOW: begin
               if (btn_s) begin
                  state    <= WAIT_HIGH;
                  busy     <= 1'b1;
                  div_cnt  <= '0;
                  stab_cnt <= '0;
               end
            end
            WAIT_HIGH: begin
               if (!btn_s) begin
                  state    <= LOW;
                  busy     <= 1'b0;
                  div_cnt  <= '0;
                  stab_cnt <= '0;
               end else if (tick) begin
                  div_cnt <= '0;
                  if (stab_cnt == STAB_LAST) begin
                     state      <= HIGH;
                     busy       <= 1'b0;
                     stab_cnt   <= '0;
                     db_level   <= 1'b1;
                     rise_pulse <= 1'b1;
                     toggle_out <= ~toggle_out;
                     press_cnt  <= press_cnt + CNT_W'(1);
                  end else begin
                     stab_cnt <= stab_cnt + STAB_W'(1);
                  end
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            HIGH: begin
               if (!btn_s) begin
                  state    <= WAIT_LOW;
                  busy     <= 1'b1;
                  div_cnt  <= '0;
                  stab_cnt <= '0;
               end
            end
            WAIT_LOW: begin
               if (btn_s) begin
                  state    <= HIGH;
                  busy     <= 1'b0;
                  div_cnt  <= '0;
                  stab_cnt <= '0;
               end else if (tick) begin
                  div_cnt <= '0;
                  if (stab_cnt == STAB_LAST) begin
                     state      <= LOW;
                     busy       <= 1'b0;
                     stab_cnt   <= '0;
                     db_level   <= 1'b0;
                     fall_pulse <= 1'b1;
                  end else begin
                     stab_cnt <= stab_cnt + STAB_W'(1);
                  end
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            default: begin
               state <= LOW;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_debounce_toggle_ctrl.sv
// Bench for debounce_toggle_ctrl: a slow instance (4x3, 8-bit count) and a fast one (1x1, 2-bit count),
// both shadowed every cycle by a run-length model of the qualification rule.
module tb_debounce_toggle_ctrl;

   localparam int RUN_A = 4 * 3 + 1;
   localparam int RUN_B = 1 * 1 + 1;

   logic       clk;
   logic       rst_a, btn_a, rst_b, btn_b;
   logic       db_a, rise_a, fall_a, tog_a, busy_a;
   logic [7:0] cnt_a;
   logic       db_b, rise_b, fall_b, tog_b, busy_b;
   logic [1:0] cnt_b;

   int  n_checks = 0;
   int  n_errors = 0;
   bit  chk_en   = 0;

   debounce_toggle_ctrl #(.TICK_DIV(4), .STABLE_TICKS(3), .CNT_W(8)) dut_a (
      .clk(clk), .reset(rst_a), .btn_in(btn_a), .db_level(db_a), .rise_pulse(rise_a),
      .fall_pulse(fall_a), .toggle_out(tog_a), .press_cnt(cnt_a), .busy(busy_a));

   debounce_toggle_ctrl #(.TICK_DIV(1), .STABLE_TICKS(1), .CNT_W(2)) dut_b (
      .clk(clk), .reset(rst_b), .btn_in(btn_b), .db_level(db_b), .rise_pulse(rise_b),
      .fall_pulse(fall_b), .toggle_out(tog_b), .press_cnt(cnt_b), .busy(busy_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // The level flips once btn_s has disagreed with it for run_len consecutive edges.
   typedef struct {
      bit sync1, btn_s, db, rise, fall, tog, busy;
      int run;
      int cnt;
   } model_t;

   model_t ma, mb;

   function automatic model_t model_step(model_t m, bit rst, bit btn, int run_len, int cnt_mod);
      model_t r;
      r = m;
      if (rst) begin
         r = '{default: 0};
      end else begin
         r.sync1 = btn;
         r.btn_s = m.sync1;
         r.rise  = 1'b0;
         r.fall  = 1'b0;
         if (m.btn_s != m.db) begin
            r.run = m.run + 1;
            if (r.run == run_len) begin
               r.run = 0;
               r.db  = !m.db;
               if (r.db) begin
                  r.rise = 1'b1;
                  r.tog  = !m.tog;
                  r.cnt  = (m.cnt + 1) % cnt_mod;
               end else begin
                  r.fall = 1'b1;
               end
            end
         end else begin
            r.run = 0;
         end
         r.busy = (r.run != 0);
      end
      return r;
   endfunction

   always @(posedge clk) begin
      ma <= model_step(ma, rst_a, btn_a, RUN_A, 256);
      mb <= model_step(mb, rst_b, btn_b, RUN_B, 4);
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         checkOutput("cyc_a", {19'b0, db_a, rise_a, fall_a, tog_a, busy_a, cnt_a},
                     {19'b0, ma.db, ma.rise, ma.fall, ma.tog, ma.busy, 8'(ma.cnt)});
         checkOutput("cyc_b", {25'b0, db_b, rise_b, fall_b, tog_b, busy_b, cnt_b},
                     {25'b0, mb.db, mb.rise, mb.fall, mb.tog, mb.busy, 2'(mb.cnt)});
      end
   end

   // Called at a negedge; returns at the negedge after `hold` active edges.
   task automatic applyStimulus(input bit on_b, input bit rst, input bit btn, input int hold);
      if (on_b) begin
         rst_b = rst;
         btn_b = btn;
      end else begin
         rst_a = rst;
         btn_a = btn;
      end
      repeat (hold) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_rise(input bit on_b, input int limit, output int edges);
      edges = -1;
      for (int i = 1; i <= limit; i++) begin
         @(posedge clk);
         @(negedge clk);
         if ((on_b ? rise_b : rise_a) === 1'b1) begin
            edges = i;
            break;
         end
      end
   endtask

   typedef struct {
      bit rst;
      bit btn;
      int hold;
      bit exp_db;
      bit exp_tog;
      int exp_cnt;
      bit exp_busy;
   } vec_t;

   vec_t vecs[9];

   initial begin
      int e, rises, falls, busy_n;
      int exp_seq[5];

      rst_a = 1'b1; btn_a = 1'b0; rst_b = 1'b1; btn_b = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_b  = 1'b0;
      chk_en = 1'b1;

      vecs[0] = '{1'b1, 1'b1,  3, 1'b0, 1'b0, 0, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 40, 1'b1, 1'b1, 1, 1'b0};
      vecs[2] = '{1'b0, 1'b0, 40, 1'b0, 1'b1, 1, 1'b0};
      vecs[3] = '{1'b0, 1'b1,  5, 1'b0, 1'b1, 1, 1'b1};
      vecs[4] = '{1'b0, 1'b0, 40, 1'b0, 1'b1, 1, 1'b0};
      vecs[5] = '{1'b0, 1'b1, 40, 1'b1, 1'b0, 2, 1'b0};
      vecs[6] = '{1'b0, 1'b0,  5, 1'b1, 1'b0, 2, 1'b1};
      vecs[7] = '{1'b1, 1'b0,  1, 1'b0, 1'b0, 0, 1'b0};
      vecs[8] = '{1'b0, 1'b0, 20, 1'b0, 1'b0, 0, 1'b0};

      for (int i = 0; i < 9; i++) begin
         applyStimulus(0, vecs[i].rst, vecs[i].btn, vecs[i].hold);
         checkOutput($sformatf("vec%0d", i), {27'b0, db_a, tog_a, busy_a, cnt_a[1:0]},
                     {27'b0, vecs[i].exp_db, vecs[i].exp_tog, vecs[i].exp_busy, 2'(vecs[i].exp_cnt)});
         if (vecs[i].rst) checkOutput($sformatf("vec%0d_fall", i), 32'(fall_a), 32'd0);
      end

      // Button held through reset: qualified from scratch once reset drops.
      applyStimulus(0, 1, 1, 3);
      checkOutput("rst_outputs", {24'b0, db_a, rise_a, fall_a, tog_a, busy_a, 3'b0}, 32'd0);
      checkOutput("rst_cnt", 32'(cnt_a), 32'd0);
      rst_a = 1'b0;
      wait_rise(0, 40, e);
      checkOutput("rst_to_rise", e, 15);
      @(posedge clk); @(negedge clk);
      checkOutput("rise_width", 32'(rise_a), 32'd0);
      checkOutput("press1_tog_cnt", {23'b0, tog_a, cnt_a}, {23'b0, 1'b1, 8'd1});

      busy_n = 0; falls = 0; rises = 0;
      btn_a = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); @(negedge clk);
         busy_n += int'(busy_a);
         falls  += int'(fall_a);
         rises  += int'(rise_a);
      end
      checkOutput("release_busy", busy_n, 12);
      checkOutput("release_fall", falls, 1);
      checkOutput("release_rise", rises, 0);
      checkOutput("release_tog_cnt", {23'b0, tog_a, cnt_a}, {23'b0, 1'b1, 8'd1});

      // Bounce: 10 high, 1 low, then high again.
      rises = 0;
      btn_a = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); @(negedge clk);
         rises += int'(rise_a);
      end
      btn_a = 1'b0;
      @(posedge clk); @(negedge clk);
      rises += int'(rise_a);
      btn_a = 1'b1;
      wait_rise(0, 40, e);
      checkOutput("bounce_no_early_rise", rises, 0);
      checkOutput("bounce_second_rise", e, 15);
      applyStimulus(0, 0, 0, 30);

      // Drop lands on the final tick: abort wins. One more high cycle qualifies.
      rises = 0;
      btn_a = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); @(negedge clk);
         rises += int'(rise_a);
      end
      btn_a = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); @(negedge clk);
         rises += int'(rise_a);
      end
      checkOutput("tick_abort_busy_before", 32'(busy_a), 32'd1);
      @(posedge clk); @(negedge clk);
      rises += int'(rise_a);
      checkOutput("tick_abort_busy_after", 32'(busy_a), 32'd0);
      checkOutput("tick_abort_db", 32'(db_a), 32'd0);
      applyStimulus(0, 0, 0, 10);
      checkOutput("tick_abort_rises", rises, 0);
      applyStimulus(0, 0, 1, 13);
      btn_a = 1'b0;
      wait_rise(0, 5, e);
      checkOutput("tick_boundary_rise", e, 2);
      applyStimulus(0, 0, 0, 30);
      checkOutput("tick_boundary_cnt", 32'(cnt_a), 32'd3);

      // Fast instance: 2-bit press counter wraps, 2-cycle qualification.
      exp_seq = '{1, 2, 3, 0, 1};
      for (int p = 0; p < 5; p++) begin
         btn_b = 1'b1;
         wait_rise(1, 10, e);
         if (p == 0) checkOutput("b_latency", e, 4);
         checkOutput($sformatf("b_cnt%0d", p), 32'(cnt_b), exp_seq[p]);
         applyStimulus(1, 0, 1, 4);
         applyStimulus(1, 0, 0, 6);
      end
      checkOutput("b_tog_final", 32'(tog_b), 32'd1);

      for (int it = 0; it < 600; it++) begin
         rst_a = ($urandom_range(0, 59) == 0);
         rst_b = ($urandom_range(0, 59) == 0);
         btn_a = 1'($urandom_range(0, 1));
         btn_b = 1'($urandom_range(0, 1));
         repeat ($urandom_range(1, 18)) @(posedge clk);
         @(negedge clk);
      end

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
